serial_adder: RTL and testbench

Bit-serial add/subtract unit built around the team's single-bit full adder: one full-adder evaluation per clock plus a registered carry, processing operands LSB first. It sits downstream of operand registers and upstream of any consumer that can tolerate WIDTH-cycle latency. It trades area for time against a ripple-carry adder. Start/done handshake; result held until the next start.

---
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder step per clock, LSB first.
// Operands captured on strt; result, carry and overflow held until next start.
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    ADD
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_shft;
  logic [WIDTH-1:0] b_shft;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic            fa_s;
  logic            fa_c;

  serial_fa u_fa (
    .a  (a_shft[0]),
    .b  (b_shft[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovfl   <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_shft <= '0;
      b_shft <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (strt) begin
            a_shft <= A;
            b_shft <= sub ? ~B : B;
            carry  <= sub;
            sum    <= '0;
            cnt    <= '0;
            cout   <= 1'b0;
            ovfl   <= 1'b0;
            busy   <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          sum    <= {fa_s, sum[WIDTH-1:1]};
          a_shft <= a_shft >> 1;
          b_shft <= b_shft >> 1;
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          // carry still holds the carry into the MSB on the last step
          if (cnt == CW'(WIDTH - 1)) begin
            cout  <= fa_c;
            ovfl  <= carry ^ fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=16.
// Each op checks busy window, done timing and result flags.
module tb_serial_adder;
  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         strt;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovfl;

  int total;
  int bad;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .strt  (strt),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovfl  (ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    A   = W'($urandom);
    B   = W'($urandom);
    sub = 1'($urandom);
  endtask

  // inj: pulse strt with A=FFFF across ADD edge 5
  task automatic op(input string tag,
                    input logic s,
                    input logic [W-1:0] a,
                    input logic [W-1:0] b,
                    input logic [W-1:0] es,
                    input logic ec,
                    input logic eo,
                    input logic inj);
    int glitch;
    glitch = 0;
    @(negedge clk);
    strt = 1'b1;
    sub  = s;
    A    = a;
    B    = b;
    @(posedge clk);
    #1;
    chk({tag, ".busy0"}, 64'(busy), 64'd1);
    chk({tag, ".done0"}, 64'(done), 64'd0);
    strt = 1'b0;
    scramble();
    for (int i = 1; i < W; i++) begin
      @(posedge clk);
      #1;
      if (!busy || done) glitch++;
      scramble();
      strt = 1'b0;
      if (inj && i == 4) begin
        strt = 1'b1;
        A    = 16'hFFFF;
      end
    end
    chk({tag, ".busywin"}, 64'(glitch), 64'd0);
    @(posedge clk);
    #1;
    strt = 1'b0;
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".sum"}, 64'(sum), 64'(es));
    chk({tag, ".cout"}, 64'(cout), 64'(ec));
    chk({tag, ".ovfl"}, 64'(ovfl), 64'(eo));
    @(posedge clk);
    #1;
    chk({tag, ".done_off"}, 64'(done), 64'd0);
    chk({tag, ".hold"}, 64'(sum), 64'(es));
    if (inj) begin
      glitch = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (busy || done) glitch++;
      end
      chk({tag, ".no_second"}, 64'(glitch), 64'd0);
    end
  endtask

  initial begin
    int cnt_done;
    int prev;
    int gap_bad;
    int sum_bad;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    strt  = 1'b0;
    sub   = 1'b0;
    A     = '0;
    B     = '0;
    #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.sum",  64'(sum),  64'd0);
    chk("rst.cout", 64'(cout), 64'd0);
    chk("rst.ovfl", 64'(ovfl), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op("add1",  1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0);
    op("addov", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    op("addwr", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
    op("sub1",  1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op("subov", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    op("ign",   1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);

    // async reset mid-operation
    @(negedge clk);
    strt = 1'b1;
    sub  = 1'b0;
    A    = 16'h1234;
    B    = 16'h4321;
    @(posedge clk);
    #1;
    strt = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid.busy_pre", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.busy", 64'(busy), 64'd0);
    chk("mid.done", 64'(done), 64'd0);
    chk("mid.sum",  64'(sum),  64'd0);
    chk("mid.cout", 64'(cout), 64'd0);
    chk("mid.ovfl", 64'(ovfl), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt_done++;
    end
    chk("mid.no_done", 64'(cnt_done), 64'd0);
    op("post", 1'b0, 16'h00FF, 16'h0F01, 16'h1000, 1'b0, 1'b0, 1'b0);

    // strt held high: back-to-back ops every W+1 cycles
    @(negedge clk);
    strt = 1'b1;
    sub  = 1'b0;
    A    = 16'h0003;
    B    = 16'h0004;
    cnt_done = 0;
    prev     = -1;
    gap_bad  = 0;
    sum_bad  = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cnt_done++;
        if (sum !== 16'h0007) sum_bad++;
        if (prev < 0 && i != W) gap_bad++;
        if (prev >= 0 && i - prev != W + 1) gap_bad++;
        prev = i;
      end
    end
    strt = 1'b0;
    chk("held.pulses", 64'(cnt_done), 64'd3);
    chk("held.gap",    64'(gap_bad),  64'd0);
    chk("held.sum",    64'(sum_bad),  64'd0);
    repeat (W + 2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
